// File: rtl/alu_pkg.sv
// Shared ALU definitions: slice default, flag-vector layout and operation mode encoding.
package alu_pkg;

  localparam int unsigned SliceDefault = 4;

  // Flag-vector bit positions.
  localparam int unsigned FlagC    = 0;
  localparam int unsigned FlagV    = 1;
  localparam int unsigned FlagZ    = 2;
  localparam int unsigned FlagN    = 3;
  localparam int unsigned NumFlags = 4;

  typedef enum logic {
    ALU_ADD = 1'b0,
    ALU_SUB = 1'b1
  } alu_mode_e;

endpackage

// File: rtl/cla_slice.sv
// Combinational carry-lookahead slice; also exports the carry into its MSB for overflow detection.
module cla_slice
  import alu_pkg::*;
#(
  parameter int unsigned SLICE = SliceDefault
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             c_in,
  output logic [SLICE-1:0] sum,
  output logic             c_out,
  output logic             c_msb
);

  logic [SLICE-1:0] g;
  logic [SLICE-1:0] p;
  logic [SLICE:0]   carry;
  logic             acc;
  logic             term;

  assign g = a & b;
  assign p = a | b;

  // Flattened lookahead: carry[i] = c_in & p[0..i-1] | OR_j (g[j] & p[j+1..i-1]).
  always_comb begin
    carry = '0;
    acc   = 1'b0;
    term  = 1'b0;
    for (int unsigned i = 0; i <= SLICE; i++) begin
      acc = c_in;
      for (int unsigned j = 0; j < i; j++) begin
        acc = acc & p[j];
      end
      for (int unsigned j = 0; j < i; j++) begin
        term = g[j];
        for (int unsigned m = j + 1; m < i; m++) begin
          term = term & p[m];
        end
        acc = acc | term;
      end
      carry[i] = acc;
    end
  end

  assign sum   = a ^ b ^ carry[SLICE-1:0];
  assign c_out = carry[SLICE];
  assign c_msb = carry[SLICE-1];

endmodule

// File: rtl/pipelined_cla_addsub.sv
// Pipelined carry-lookahead adder/subtractor: one lookahead slice per stage, registered
// inter-slice carry, skewed upper operands, registered result and flags, valid/ready flow.
module pipelined_cla_addsub
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SLICE = SliceDefault
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             overflow,
  output logic             zero,
  output logic             negative
);

  localparam int unsigned STAGES = WIDTH / SLICE;

  logic             adv;
  logic             take;
  logic [WIDTH-1:0] b_adj;

  // The whole pipeline moves in lockstep; a stalled output freezes every stage.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;
  assign take     = in_valid && adv;
  assign b_adj    = (alu_mode_e'(sub) == ALU_SUB) ? ~b : b;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    // Operand bits still to be consumed: slice k at the bottom, later slices above it.
    localparam int unsigned OpW = WIDTH - k * SLICE;

    logic [OpW-1:0]         op_a;
    logic [OpW-1:0]         op_b;
    logic                   c_prev;
    logic                   v_prev;
    logic [SLICE-1:0]       slice_sum;
    logic                   slice_c;
    logic                   slice_cm;
    logic [(k+1)*SLICE-1:0] sum_next;
    logic [(k+1)*SLICE-1:0] sum_q;
    logic                   valid_q;

    if (k == 0) begin : g_first
      assign op_a     = a;
      assign op_b     = b_adj;
      assign c_prev   = c_in;
      assign v_prev   = take;
      assign sum_next = slice_sum;
    end else begin : g_next
      assign op_a     = g_stage[k-1].g_fwd.a_q;
      assign op_b     = g_stage[k-1].g_fwd.b_q;
      assign c_prev   = g_stage[k-1].g_fwd.carry_q;
      assign v_prev   = g_stage[k-1].valid_q;
      assign sum_next = {slice_sum, g_stage[k-1].sum_q};
    end

    cla_slice #(
      .SLICE(SLICE)
    ) u_slice (
      .a    (op_a[SLICE-1:0]),
      .b    (op_b[SLICE-1:0]),
      .c_in (c_prev),
      .sum  (slice_sum),
      .c_out(slice_c),
      .c_msb(slice_cm)
    );

    // Stage valid and accumulated low result bits.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_q <= 1'b0;
        sum_q   <= '0;
      end else if (adv) begin
        valid_q <= v_prev;
        sum_q   <= sum_next;
      end
    end

    if (k < STAGES - 1) begin : g_fwd
      logic [OpW-SLICE-1:0] a_q;
      logic [OpW-SLICE-1:0] b_q;
      logic                 carry_q;
      logic                 unused_cm;

      assign unused_cm = slice_cm;

      // Skew the not-yet-used operand slices and carry forward to the next stage.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q     <= '0;
          b_q     <= '0;
          carry_q <= 1'b0;
        end else if (adv) begin
          a_q     <= op_a[OpW-1:SLICE];
          b_q     <= op_b[OpW-1:SLICE];
          carry_q <= slice_c;
        end
      end
    end else begin : g_last
      logic [NumFlags-1:0] flags_q;

      // Status flags are derived from the fully assembled result and registered with it.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          flags_q <= '0;
        end else if (adv) begin
          flags_q[FlagC] <= slice_c;
          flags_q[FlagV] <= slice_cm ^ slice_c;
          flags_q[FlagZ] <= ~|sum_next;
          flags_q[FlagN] <= sum_next[WIDTH-1];
        end
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].valid_q;
  assign sum       = g_stage[STAGES-1].sum_q;
  assign c_out     = g_stage[STAGES-1].g_last.flags_q[FlagC];
  assign overflow  = g_stage[STAGES-1].g_last.flags_q[FlagV];
  assign zero      = g_stage[STAGES-1].g_last.flags_q[FlagZ];
  assign negative  = g_stage[STAGES-1].g_last.flags_q[FlagN];

endmodule

// File: doc/pipelined_cla_addsub.md
# pipelined_cla_addsub

Parametrised, pipelined carry-lookahead adder/subtractor with valid/ready handshaking and status flags, the next-generation arithmetic core of the 8-bit computer's ALU datapath. Operands are split into fixed-width lookahead slices. Each slice is evaluated in its own pipeline stage, with the inter-slice carry registered between stages. This lets wide operands meet timing at one result per cycle. The block sits between the operand-select stage and the ALU result/flag register.

## Interface
- `WIDTH`, 8: operand and result width in bits; must be a multiple of `SLICE`.
- `SLICE`, 4: bits per lookahead slice, which is also bits per pipeline stage.
- `STAGES`, `WIDTH/SLICE` (derived, not overridable): pipeline depth.

- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  operand bundle is valid.
- `in_ready`  out  1  block accepts the bundle this cycle.
- `a`  in  WIDTH  operand A.
- `b`  in  WIDTH  operand B.
- `c_in`  in  1  carry in; in subtract mode, 1 means no borrow.
- `sub`  in  1  0 = add, 1 = subtract.
- `out_valid`  out  1  result bundle is valid.
- `out_ready`  in  1  downstream accepts the result.
- `sum`  out  WIDTH  result.
- `c_out`  out  1  carry out of the MSB; in subtract mode, 1 means no borrow.
- `overflow`  out  1  two's-complement signed overflow.
- `zero`  out  1  `sum` equals 0.
- `negative`  out  1  `sum[WIDTH-1]`.

## Operation
- **Result:** `{c_out, sum} = a + (sub ? ~b : b) + c_in`, computed modulo 2^WIDTH with the carry captured.
  - Subtract follows the 6502-style convention: `c_in=1` gives A−B.
- **Per-slice lookahead:** generate is `g=a&b'` and propagate is `p=a|b'`.
  - `b'` is the mode-adjusted B.
  - Slice carries come from the lookahead equations, not from a ripple chain.
- **Stage k (0-based):**
  - Computes slice k from its delayed operand bits and the carry registered by stage k−1.
  - Stage 0 uses `c_in`.
  - Upper-slice operands are skewed through delay registers, and completed lower result bits are delayed so all bits align at the output.
- **Flags:** evaluated on the final aligned result.
  - `overflow` = carry into the MSB XOR `c_out`.
  - `zero` = NOR over all `sum` bits.
  - `negative` = MSB of `sum`.
- **Registered outputs:** all outputs except `in_ready` are driven directly from final-stage registers.
- **Handshake:**
  - Global advance enable is `adv = !out_valid || out_ready`.
  - `in_ready = adv`.
  - A transfer occurs when `in_valid && in_ready`.
  - When `adv=0`, every stage holds, including valid bits and data; `sum` and the flags stay stable.
- **Bubbles:** a cycle with `adv=1` and no input transfer inserts a bubble (valid=0) into stage 0. Bubbles are not collapsed.
- **Ordering:** results emerge in the same order as the inputs; nothing is lost or duplicated.

## Timing
- **Latency:** a bundle accepted at edge n presents `out_valid=1` after edge n+STAGES−1, i.e. STAGES cycles with no stall.
  - With `WIDTH=8` and `SLICE=4`, latency is 2.
  - With `STAGES=1`, latency is 1.
- **Throughput:** one result per cycle while `out_ready=1`.
- **Reset:**
  - Asynchronously clears all stage valid bits, carries, data, `sum` and every flag to 0.
  - `in_ready` is 1 while in reset and after release, because `out_valid=0`.
- **Reset mid-operation:** all in-flight bundles are discarded. No stale result appears after release.
- **Simultaneous accept and output:** with the pipeline full and `out_ready=1`, a new bundle is accepted in the same cycle the oldest leaves.
- **Stall:** `in_ready` is combinational from `out_valid` and `out_ready`. It is deasserted in the cycle where `out_valid=1` and `out_ready=0`.

## Structure
- **Shared package `alu_pkg`:**
  - Default `SLICE` constant.
  - Flag-vector bit indices: C=0, V=1, Z=2, N=3.
  - Mode encoding: `ALU_ADD=0`, `ALU_SUB=1`.
- **Sub-module `cla_slice`:** a combinational, `SLICE`-parametrised lookahead slice.
  - Inputs: `a`, `b`, `c_in`.
  - Outputs: `sum`, `c_out`, and carry into the slice MSB (needed for `overflow`).
  - Instantiated STAGES times via generate.

## Test plan
- **Reset:** reset asserted → `out_valid=0`, `sum=0x00`, all flags 0, `in_ready=1`.
- **Add with signed overflow:** `WIDTH=8`, add `0x7F+0x01`, `c_in=0` → 2 cycles later `sum=0x80`, `c_out=0`, `overflow=1`, `negative=1`, `zero=0`.
- **Subtract:**
  - `0x05−0x03`, `c_in=1` → `0x02`, `c_out=1`.
  - `0x03−0x05`, `c_in=1` → `0xFE`, `c_out=0`, `negative=1`.
- **Cross-slice carry and streaming:**
  - `0xFF+0x00`, `c_in=1` → `0x00`, `c_out=1`, `zero=1`.
  - Then 16 random pairs back-to-back → results in order, one per cycle, each matching the reference model.
- **Backpressure:** pipeline full, `out_ready=0` for 3 cycles → `in_ready=0`, `sum` and flags held stable, then drains with no loss or duplication.
- **Reset mid-stream:** `rst_n` pulled low with 2 bundles in flight → `out_valid` drops immediately; after release, no output until new input is accepted.
